// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default link parameters.
// The transmitter and receiver both import this package.
package uart_pkg;

  localparam int unsigned DefaultClksPerBit = 10417;
  localparam int unsigned DefaultDataBits   = 8;
  localparam int unsigned StateW            = 3;

  typedef enum logic [StateW-1:0] {
    StIdle      = 3'd0,
    StStart     = 3'd1,
    StData      = 3'd2,
    StStop      = 3'd3,
    StBreakWait = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so the line looks idle immediately after reset.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: finds the start bit, samples each bit mid-period,
// strobes data_valid on a good stop bit and framing_error on a bad one.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_BITS    = DefaultDataBits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] Half    = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_receiver: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 2) begin : g_bad_data_bits
    $error("uart_receiver: DATA_BITS must be at least 2");
  end

  logic rx_s;

  uart_rx_sync u_rx_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .rx_i    (rx_in),
    .rx_s_o  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == Half) begin
          cnt_d = '0;
          if (!rx_s) begin
            idx_d   = '0;
            state_d = StData;
          end else begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the top leaves it in bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StBreakWait;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StBreakWait: begin
        // A held-low line must not be decoded as a stream of zero bytes.
        cnt_d = '0;
        idx_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a fast instance (16 clocks/bit) for framing
// tests and a default-parameter instance for reset and glitch behaviour.
module tb_uart_receiver;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  logic       rx2;
  logic [7:0] d2_data;
  logic       d2_valid;
  logic       d2_fe;
  logic       d2_busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (8)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  uart_receiver u_dut_def (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx2),
    .data_out      (d2_data),
    .data_valid    (d2_valid),
    .framing_error (d2_fe),
    .busy          (d2_busy)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_valid = 0;
  int         n_fe = 0;
  int         d2_events = 0;
  int         cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] sb[$];
  int         valid_cyc[$];
  int         frame_start[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        check_eq("valid_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check_eq("data_out", data_out, sb.pop_front());
        check_eq("valid_fe_exclusive", framing_error, 0);
        check_eq("valid_one_cycle", prev_valid, 0);
        valid_cyc.push_back(cyc);
        n_valid++;
      end
      if (framing_error) begin
        check_eq("fe_one_cycle", prev_fe, 0);
        n_fe++;
      end
      if (d2_valid || d2_fe) d2_events++;
    end
    prev_valid <= data_valid;
    prev_fe    <= framing_error;
  end

  // Advance n clock edges, then step just past the edge so drives never race it.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    frame_start.push_back(cyc);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  int lat;
  int gap;
  int nv0;

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    rx2   = 1'b1;
    tick(3);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_fe", framing_error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("def_rst_data_out", d2_data, 8'h00);
    check_eq("def_rst_busy", d2_busy, 0);
    reset = 1'b0;
    tick(4);

    // Test 1: ideal 0xA5 frame
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(Cpb);
    check_eq("t1_valid_count", n_valid, 1);
    check_eq("t1_fe_count", n_fe, 0);
    check_eq("t1_data_out", data_out, 8'hA5);
    check_eq("t1_busy_after", busy, 0);
    if (valid_cyc.size() >= 1) begin
      lat = valid_cyc[0] - frame_start[0];
      check_eq("t1_latency_near_155", (lat >= 153) && (lat <= 157), 1);
    end

    // Test 2: 5-clock low glitch
    rx_in = 1'b0;
    tick(5);
    check_eq("t2_busy_in_start", busy, 1);
    rx_in = 1'b1;
    tick(2 * Cpb);
    check_eq("t2_busy_after", busy, 0);
    check_eq("t2_valid_count", n_valid, 1);
    check_eq("t2_fe_count", n_fe, 0);
    check_eq("t2_data_out_held", data_out, 8'hA5);

    // Test 3: bad stop bit, then line held low for 3 bit periods
    send_frame(8'h3C, 1'b0);
    tick(3 * Cpb);
    check_eq("t3_busy_break_wait", busy, 1);
    check_eq("t3_fe_count", n_fe, 1);
    rx_in = 1'b1;
    tick(2 * Cpb);
    check_eq("t3_busy_after", busy, 0);
    check_eq("t3_valid_count", n_valid, 1);
    check_eq("t3_fe_count_after", n_fe, 1);
    check_eq("t3_data_out_held", data_out, 8'hA5);

    // Test 4: back-to-back 0x00, 0xFF with no idle gap
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(Cpb);
    check_eq("t4_valid_count", n_valid, 3);
    check_eq("t4_data_out", data_out, 8'hFF);
    if (valid_cyc.size() >= 3) begin
      gap = valid_cyc[2] - valid_cyc[1];
      check_eq("t4_gap_10_bits", (gap >= 158) && (gap <= 162), 1);
    end

    // Test 5: reset mid bit 4 of 0x81, then a clean 0x42
    nv0 = n_valid;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0);
    rx_in = 1'b0;
    tick(Cpb / 2);
    reset = 1'b1;
    rx_in = 1'b1;
    tick(2);
    check_eq("t5_rst_data_out", data_out, 8'h00);
    check_eq("t5_rst_valid", data_valid, 0);
    check_eq("t5_rst_fe", framing_error, 0);
    check_eq("t5_rst_busy", busy, 0);
    reset = 1'b0;
    tick(2 * Cpb);
    check_eq("t5_no_aborted_output", n_valid, nv0);
    check_eq("t5_busy_idle", busy, 0);
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    tick(Cpb);
    check_eq("t5_valid_count", n_valid, nv0 + 1);
    check_eq("t5_data_out", data_out, 8'h42);

    // Default-parameter instance: glitch shorter than half a bit is rejected
    rx2 = 1'b0;
    tick(5);
    check_eq("def_busy_in_start", d2_busy, 1);
    rx2 = 1'b1;
    tick(5300);
    check_eq("def_busy_after_glitch", d2_busy, 0);
    check_eq("def_no_events", d2_events, 0);
    check_eq("def_data_out_held", d2_data, 8'h00);

    check_eq("sb_drained", sb.size(), 0);
    check_eq("total_valid", n_valid, 4);
    check_eq("total_fe", n_fe, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
